fetch_sequencer: RTL and testbench

- Controls the program counter register: produces its next-value input and active-low load enable, and runs the fetch/execute cycle for a multi-cycle, non-pipelined RV32 core.
- Issues instruction fetches at the current PC over a request/acknowledge handshake and holds the fetched instruction for the execute stage.
- Selects the next PC from sequential, redirect, trap and mret sources, and records the exception PC and cause.

---
 rtl/fetch_sequencer_if.sv | 25 ++
 rtl/fetch_sequencer.sv | 133 +++++++++++++
 tb/tb_fetch_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Instruction-fetch request/acknowledge channel between the fetch sequencer
// (master) and instruction memory (slave).
interface fetch_sequencer_if;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic [31:0] fetch_data;
    logic        fetch_error;

    modport master (
        output fetch_req,
        output fetch_addr,
        input  fetch_ack,
        input  fetch_data,
        input  fetch_error
    );

    modport slave (
        input  fetch_req,
        input  fetch_addr,
        output fetch_ack,
        output fetch_data,
        output fetch_error
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer for a multi-cycle, non-pipelined RV32 core: drives the
// external PC register, issues fetches, latches instructions, handles traps/mret.
module fetch_sequencer #(
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [31:0]                pc,
    output logic [31:0]                pc_next,
    output logic                       pc_enable_n,
    fetch_sequencer_if.master          fetch,
    output logic [31:0]                instr,
    output logic                       instr_valid,
    input  logic                       exec_done,
    input  logic                       redirect,
    input  logic [31:0]                redirect_target,
    input  logic                       trap_req,
    input  logic [3:0]                 trap_cause_in,
    input  logic                       mret,
    output logic [31:0]                epc,
    output logic [3:0]                 mcause
);

    // One-hot encoding leaves two unreachable codes; both fall back to FETCH.
    typedef enum logic [1:0] {
        S_FETCH = 2'b01,
        S_EXEC  = 2'b10
    } state_t;

    localparam logic [3:0] CAUSE_MISALIGNED  = 4'd0;
    localparam logic [3:0] CAUSE_FETCH_FAULT = 4'd1;

    state_t      r_state;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic [31:0] r_epc;
    logic [3:0]  r_mcause;

    state_t      w_state_next;
    logic [31:0] w_instr_next;
    logic        w_instr_valid_next;
    logic [31:0] w_epc_next;
    logic [3:0]  w_mcause_next;
    logic [31:0] w_pc_next;
    logic        w_pc_enable_n;
    logic        w_fetch_req;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = pc + 32'd4;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_FETCH;
            r_instr       <= 32'd0;
            r_instr_valid <= 1'b0;
            r_epc         <= 32'd0;
            r_mcause      <= 4'd0;
        end else begin
            r_state       <= w_state_next;
            r_instr       <= w_instr_next;
            r_instr_valid <= w_instr_valid_next;
            r_epc         <= w_epc_next;
            r_mcause      <= w_mcause_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_instr_next       = r_instr;
        w_instr_valid_next = r_instr_valid;
        w_epc_next         = r_epc;
        w_mcause_next      = r_mcause;
        w_pc_next          = w_pc_plus4;
        w_pc_enable_n      = 1'b1;
        w_fetch_req        = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_fetch_req = 1'b1;
                if (fetch.fetch_ack) begin
                    if (fetch.fetch_error) begin
                        w_pc_next     = TRAP_VECTOR;
                        w_pc_enable_n = 1'b0;
                        w_epc_next    = pc;
                        w_mcause_next = CAUSE_FETCH_FAULT;
                    end else begin
                        w_instr_next       = fetch.fetch_data;
                        w_instr_valid_next = 1'b1;
                        w_state_next       = S_EXEC;
                    end
                end
            end

            S_EXEC: begin
                if (exec_done) begin
                    w_pc_enable_n      = 1'b0;
                    w_instr_valid_next = 1'b0;
                    w_state_next       = S_FETCH;
                    // Next-PC sources in strict priority order.
                    if (trap_req) begin
                        w_pc_next     = TRAP_VECTOR;
                        w_epc_next    = pc;
                        w_mcause_next = trap_cause_in;
                    end else if (mret) begin
                        w_pc_next = r_epc;
                    end else if (redirect && (redirect_target[1:0] != 2'b00)) begin
                        w_pc_next     = TRAP_VECTOR;
                        w_epc_next    = pc;
                        w_mcause_next = CAUSE_MISALIGNED;
                    end else if (redirect) begin
                        w_pc_next = redirect_target;
                    end
                end
            end

            default: begin
                w_state_next       = S_FETCH;
                w_instr_valid_next = 1'b0;
            end
        endcase
    end

    // Reset must silence the request and PC load without waiting for a clock.
    assign fetch.fetch_req  = w_fetch_req & reset_n;
    assign fetch.fetch_addr = pc;
    assign pc_enable_n      = w_pc_enable_n | ~reset_n;
    assign pc_next          = w_pc_next;
    assign instr            = r_instr;
    assign instr_valid      = r_instr_valid;
    assign epc              = r_epc;
    assign mcause           = r_mcause;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural PC register alongside it.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset_n;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        pc_enable_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        trap_req;
    logic [3:0]  trap_cause_in;
    logic        mret;
    logic [31:0] epc;
    logic [3:0]  mcause;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_sequencer_if fif ();

    fetch_sequencer #(.TRAP_VECTOR(32'h0000_0100)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .pc              (pc),
        .pc_next         (pc_next),
        .pc_enable_n     (pc_enable_n),
        .fetch           (fif.master),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .exec_done       (exec_done),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .trap_req        (trap_req),
        .trap_cause_in   (trap_cause_in),
        .mret            (mret),
        .epc             (epc),
        .mcause          (mcause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         pc <= 32'd0;
        else if (!pc_enable_n) pc <= pc_next;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_exec();
        exec_done = 0; redirect = 0; redirect_target = 0;
        trap_req = 0; trap_cause_in = 0; mret = 0;
    endtask

    // Called at negedge+1 in FETCH: acks the fetch, lands at negedge+1 in EXEC.
    task automatic fetch_ok(input logic [31:0] exp_addr, input logic [31:0] data);
        check("fetch_req", {31'd0, fif.fetch_req}, 32'd1);
        check("fetch_addr", fif.fetch_addr, exp_addr);
        fif.fetch_ack = 1; fif.fetch_data = data; fif.fetch_error = 0;
        #1 check("en_n_on_ack", {31'd0, pc_enable_n}, 32'd1);
        @(negedge clk); fif.fetch_ack = 0; #1;
        check("instr", instr, data);
        check("instr_valid", {31'd0, instr_valid}, 32'd1);
        check("req_in_exec", {31'd0, fif.fetch_req}, 32'd0);
        $display("[TB] fetch addr=%h data=%h", exp_addr, data);
    endtask

    // Called at negedge+1 in EXEC: completes execute, lands at negedge+1 in FETCH.
    task automatic exec_fin(input logic tr, input logic [3:0] cause, input logic mr,
                            input logic rd, input logic [31:0] tgt, input logic [31:0] exp_next);
        exec_done = 1; trap_req = tr; trap_cause_in = cause; mret = mr;
        redirect = rd; redirect_target = tgt;
        #1;
        check("en_n_on_done", {31'd0, pc_enable_n}, 32'd0);
        check("pc_next", pc_next, exp_next);
        @(negedge clk); clear_exec(); #1;
        check("pc_loaded", pc, exp_next);
        check("valid_cleared", {31'd0, instr_valid}, 32'd0);
        $display("[TB] exec trap=%0d mret=%0d redir=%0d tgt=%h -> pc=%h", tr, mr, rd, tgt, exp_next);
    endtask

    initial begin
        reset_n = 0;
        clear_exec();
        fif.fetch_ack = 0; fif.fetch_data = 0; fif.fetch_error = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", {31'd0, fif.fetch_req}, 32'd0);
        check("rst_en_n", {31'd0, pc_enable_n}, 32'd1);
        check("rst_instr", instr, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_epc", epc, 32'd0);
        check("rst_mcause", {28'd0, mcause}, 32'd0);
        @(negedge clk); reset_n = 1; #1;

        // Sequential: 0,4,8,12
        for (int i = 0; i < 4; i++) begin
            fetch_ok(32'(i * 4), 32'hA000_0000 + 32'(i));
            exec_fin(0, 4'd0, 0, 0, 32'd0, 32'(i * 4 + 4));
        end

        // exec_done in FETCH is ignored; memory stalls for 5 cycles at 0x10
        exec_done = 1;
        for (int i = 0; i < 5; i++) begin
            check("stall_req", {31'd0, fif.fetch_req}, 32'd1);
            check("stall_addr", fif.fetch_addr, 32'h10);
            check("stall_en_n", {31'd0, pc_enable_n}, 32'd1);
            check("stall_valid", {31'd0, instr_valid}, 32'd0);
            @(negedge clk); #1;
            check("stall_pc", pc, 32'h10);
        end
        exec_done = 0; #1;
        fetch_ok(32'h10, 32'h0000_0013);

        // Aligned then misaligned redirect
        exec_fin(0, 4'd0, 0, 1, 32'h200, 32'h200);
        fetch_ok(32'h200, 32'h1111_1111);
        exec_fin(0, 4'd0, 0, 1, 32'h202, 32'h100);
        check("misalign_epc", epc, 32'h200);
        check("misalign_cause", {28'd0, mcause}, 32'd0);

        // Trap beats redirect; then mret beats redirect
        fetch_ok(32'h100, 32'h2222_2222);
        exec_fin(0, 4'd0, 0, 0, 32'd0, 32'h104);
        fetch_ok(32'h104, 32'h3333_3333);
        exec_fin(1, 4'd11, 0, 1, 32'h300, 32'h100);
        check("trap_epc", epc, 32'h104);
        check("trap_cause", {28'd0, mcause}, 32'd11);
        fetch_ok(32'h100, 32'h3000_0073);
        exec_fin(0, 4'd0, 1, 1, 32'h300, 32'h104);
        check("mret_epc", epc, 32'h104);
        check("mret_cause", {28'd0, mcause}, 32'd11);

        // Fetch access fault at 0x40
        fetch_ok(32'h104, 32'h4444_4444);
        exec_fin(0, 4'd0, 0, 1, 32'h40, 32'h40);
        check("ferr_addr", fif.fetch_addr, 32'h40);
        fif.fetch_ack = 1; fif.fetch_error = 1; fif.fetch_data = 32'hDEAD_BEEF; #1;
        check("ferr_en_n", {31'd0, pc_enable_n}, 32'd0);
        check("ferr_pc_next", pc_next, 32'h100);
        @(negedge clk); fif.fetch_ack = 0; fif.fetch_error = 0; #1;
        check("ferr_pc", pc, 32'h100);
        check("ferr_epc", epc, 32'h40);
        check("ferr_cause", {28'd0, mcause}, 32'd1);
        check("ferr_valid", {31'd0, instr_valid}, 32'd0);
        check("ferr_instr", instr, 32'h4444_4444);
        check("ferr_req", {31'd0, fif.fetch_req}, 32'd1);
        $display("[TB] fetch error at 40 -> pc=%h epc=%h mcause=%0d", pc, epc, mcause);

        // Wrap from 0xFFFF_FFFC
        fetch_ok(32'h100, 32'h5555_5555);
        exec_fin(0, 4'd0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        fetch_ok(32'hFFFF_FFFC, 32'h6666_6666);
        exec_fin(0, 4'd0, 0, 0, 32'd0, 32'd0);

        // Reset in EXEC
        fetch_ok(32'd0, 32'h7777_7777);
        exec_done = 1;
        reset_n = 0; #1;
        check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        check("mid_rst_req", {31'd0, fif.fetch_req}, 32'd0);
        check("mid_rst_en_n", {31'd0, pc_enable_n}, 32'd1);
        check("mid_rst_epc", epc, 32'd0);
        exec_done = 0;
        @(negedge clk); reset_n = 1; #1;
        check("post_rst_req", {31'd0, fif.fetch_req}, 32'd1);
        check("post_rst_addr", fif.fetch_addr, 32'd0);
        $display("[TB] reset in EXEC -> fetch_addr=%h", fif.fetch_addr);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
